x2_multiplier: RTL and testbench

Final stage of the three-stage multiplier pipeline (X0 → X1 → X2). It is the consumer end of the x1x2 FIFO.
- Pops carry-save pairs from the x1x2 FIFO.
- Resolves each pair with a two-cycle split carry-propagate add.
- Selects the upper or lower 32-bit word of the 64-bit product.
- Pushes the word into an x2wbk FIFO that the writeback stage drains.

---
 rtl/x2_multiplier_pkg.sv | 10 +
 rtl/x2_multiplier_if.sv | 26 ++
 rtl/x2_multiplier_fifo.sv | 61 ++++++
 rtl/x2_multiplier.sv | 89 ++++++++
 tb/tb_x2_multiplier.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/x2_multiplier_pkg.sv
// Shared constants for the multiplier pipeline: word width, carry-save field
// offsets and the x2wbk entry layout.
package mult_pkg;
  localparam int XLEN      = 32;
  localparam int PROD_W    = 2 * XLEN;
  localparam int CS_W      = 4 * XLEN;
  localparam int SUM_LSB   = 0;
  localparam int CARRY_LSB = 64;
  localparam int X2WBK_W   = XLEN + 1;
endpackage

// File: rtl/x2_multiplier_if.sv
// X1->X2 carry-save hand-off and X2->writeback result port of the final
// multiplier stage.
interface x2_multiplier_if;
  import mult_pkg::*;

  logic [CS_W-1:0] RES_RX1;
  logic            SELECT_MSB_RX1;
  logic            SIGNED_RES_RX1;
  logic            X1X2_EMPTY_SX1;
  logic            X1X2_POP_SX2;
  logic            X2WBK_POP_SWBK;
  logic [XLEN-1:0] RES_RX2;
  logic            SIGNED_RES_RX2;
  logic            X2WBK_EMPTY_SX2;
  logic            MULT_BUSY_SX2;

  modport slave (
    input  RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1, X2WBK_POP_SWBK,
    output X1X2_POP_SX2, RES_RX2, SIGNED_RES_RX2, X2WBK_EMPTY_SX2, MULT_BUSY_SX2
  );

  modport master (
    output RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1, X2WBK_POP_SWBK,
    input  X1X2_POP_SX2, RES_RX2, SIGNED_RES_RX2, X2WBK_EMPTY_SX2, MULT_BUSY_SX2
  );
endinterface

// File: rtl/x2_multiplier_fifo.sv
// Synchronous FIFO with registered EMPTY/FULL flags; head reads as zero when
// empty. DEPTH must be a power of two.
module x2_multiplier_fifo #(
  parameter int N     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [N-1:0] i_din,
  input  logic         i_pop,
  output logic [N-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_empty;
  logic          r_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop)      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_do_pop && !w_do_push) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_empty ? '0 : r_mem[r_rd];
  assign o_empty = r_empty;
  assign o_full  = r_full;
endmodule

// File: rtl/x2_multiplier.sv
// Final multiplier stage: resolves X1 carry-save pairs with a split two-cycle
// add, selects the upper/lower product word and queues it for writeback.
module x2_multiplier
  import mult_pkg::*;
#(
  parameter int X2WBK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  x2_multiplier_if.slave    mif
);
  function automatic logic [XLEN:0] add_lo(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [XLEN-1:0] add_hi(input logic [XLEN-1:0] s, input logic [XLEN-1:0] c,
                                             input logic cin);
    return s + c + {{(XLEN-1){1'b0}}, cin};
  endfunction

  logic [PROD_W-1:0]  w_sum;
  logic [PROD_W-1:0]  w_carry;
  logic               w_pop;
  logic               w_rdy;
  logic               w_push_p1;
  logic               w_full;
  logic               w_empty;
  logic [XLEN-1:0]    w_hi_p1;
  logic [XLEN-1:0]    w_word_p1;
  logic [X2WBK_W-1:0] w_din_p1;
  logic [X2WBK_W-1:0] w_dout;

  logic               r_vld_p0;
  logic [XLEN:0]      r_lo_p0;
  logic [XLEN-1:0]    r_hi_s_p0;
  logic [XLEN-1:0]    r_hi_c_p0;
  logic               r_sel_p0;
  logic               r_sgn_p0;

  assign w_sum   = mif.RES_RX1[SUM_LSB +: PROD_W];
  assign w_carry = mif.RES_RX1[CARRY_LSB +: PROD_W];

  // FULL is registered, so a writeback pop in the same cycle never frees a slot here.
  assign w_push_p1 = r_vld_p0 & ~w_full;
  assign w_rdy     = ~r_vld_p0 | w_push_p1;
  assign w_pop     = reset_n & ~mif.X1X2_EMPTY_SX1 & w_rdy;

  // Stage A: low-half add with carry-out, high halves captured unresolved
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_vld_p0 <= 1'b0;
    else if (w_pop)     r_vld_p0 <= 1'b1;
    else if (w_push_p1) r_vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_lo_p0   <= add_lo(w_sum[XLEN-1:0], w_carry[XLEN-1:0]);
      r_hi_s_p0 <= w_sum[PROD_W-1:XLEN];
      r_hi_c_p0 <= w_carry[PROD_W-1:XLEN];
      r_sel_p0  <= mif.SELECT_MSB_RX1;
      r_sgn_p0  <= mif.SIGNED_RES_RX1;
    end
  end

  // Stage B: high-half add absorbs the low carry; bit 64 of the product is dropped
  assign w_hi_p1   = add_hi(r_hi_s_p0, r_hi_c_p0, r_lo_p0[XLEN]);
  assign w_word_p1 = r_sel_p0 ? w_hi_p1 : r_lo_p0[XLEN-1:0];
  assign w_din_p1  = {r_sgn_p0, w_word_p1};

  x2_multiplier_fifo #(
    .N     (X2WBK_W),
    .DEPTH (X2WBK_DEPTH)
  ) x2wbk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push_p1),
    .i_din   (w_din_p1),
    .i_pop   (mif.X2WBK_POP_SWBK),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign mif.X1X2_POP_SX2    = w_pop;
  assign mif.RES_RX2         = w_dout[XLEN-1:0];
  assign mif.SIGNED_RES_RX2  = w_dout[XLEN];
  assign mif.X2WBK_EMPTY_SX2 = w_empty;
  assign mif.MULT_BUSY_SX2   = r_vld_p0 | ~w_empty;
endmodule

// File: tb/tb_x2_multiplier.sv
// Randomised bench for x2_multiplier: a queue-level model of the X1 source and
// the in-flight entries, plus directed carry/wrap/sign vectors.
module tb_x2_multiplier;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic        sel;
    logic        sgn;
    int          pc;
  } ent_t;

  logic clk;
  logic reset_n;
  x2_multiplier_if mif();

  x2_multiplier #(.X2WBK_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mif     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t src_q[$];
  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   wb_en = 0;
  int   wb_pct = 100;

  function automatic logic [31:0] mword(input ent_t e);
    logic [63:0] p;
    p = e.s + e.c;
    return e.sel ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  task automatic add_src(input logic [63:0] s, input logic [63:0] c, input logic sel, input logic sgn);
    ent_t e;
    e.s = s; e.c = c; e.sel = sel; e.sgn = sgn; e.pc = 0;
    src_q.push_back(e);
  endtask

  task automatic check_outputs();
    bit head_ready;
    head_ready = (exp_q.size() > 0) && (exp_q[0].pc <= cyc - 2);
    chk("busy", 64'(mif.MULT_BUSY_SX2), 64'(exp_q.size() != 0));
    chk("empty", 64'(mif.X2WBK_EMPTY_SX2), 64'(!head_ready));
    if (!mif.X2WBK_EMPTY_SX2 && exp_q.size() > 0)
      chk("head", 64'({mif.SIGNED_RES_RX2, mif.RES_RX2}), 64'({exp_q[0].sgn, mword(exp_q[0])}));
    if (src_q.size() == 0)          chk("pop_idle", 64'(mif.X1X2_POP_SX2), 64'd0);
    else if (exp_q.size() <= DEPTH) chk("pop_thru", 64'(mif.X1X2_POP_SX2), 64'd1);
    else                            chk("pop_full", 64'(mif.X1X2_POP_SX2), 64'd0);
  endtask

  task automatic step();
    ent_t e;
    @(negedge clk);
    if (src_q.size() > 0) begin
      mif.X1X2_EMPTY_SX1 = 1'b0;
      mif.RES_RX1        = {src_q[0].c, src_q[0].s};
      mif.SELECT_MSB_RX1 = src_q[0].sel;
      mif.SIGNED_RES_RX1 = src_q[0].sgn;
    end else begin
      mif.X1X2_EMPTY_SX1 = 1'b1;
      mif.RES_RX1        = {$urandom, $urandom, $urandom, $urandom};
    end
    mif.X2WBK_POP_SWBK = wb_en && ($urandom_range(0, 99) < wb_pct);
    #1;
    check_outputs();
    if (mif.X1X2_POP_SX2 && src_q.size() > 0) begin
      e = src_q.pop_front();
      e.pc = cyc;
      exp_q.push_back(e);
    end
    if (mif.X2WBK_POP_SWBK && !mif.X2WBK_EMPTY_SX2 && exp_q.size() > 0)
      e = exp_q.pop_front();
    cyc++;
  endtask

  task automatic drain();
    int n;
    wb_en = 1; wb_pct = 100; n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
      step();
      n++;
    end
    if (src_q.size() > 0 || exp_q.size() > 0) timeout("drain");
  endtask

  task automatic directed(input string nm, input logic [63:0] s, input logic [63:0] c,
                          input logic sel, input logic sgn, input logic [31:0] ew, input logic es);
    int n;
    drain();
    wb_en = 0;
    add_src(s, c, sel, sgn);
    n = 0;
    do begin
      step();
      n++;
    end while (mif.X2WBK_EMPTY_SX2 && n < 10);
    if (mif.X2WBK_EMPTY_SX2) timeout(nm);
    else chk(nm, 64'({mif.SIGNED_RES_RX2, mif.RES_RX2}), 64'({es, ew}));
    drain();
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    mif.RES_RX1 = '0; mif.SELECT_MSB_RX1 = 0; mif.SIGNED_RES_RX1 = 0;
    mif.X1X2_EMPTY_SX1 = 1'b1; mif.X2WBK_POP_SWBK = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(mif.MULT_BUSY_SX2), 64'd0);
    chk("rst_pop", 64'(mif.X1X2_POP_SX2), 64'd0);
    chk("rst_empty", 64'(mif.X2WBK_EMPTY_SX2), 64'd1);
    chk("rst_res", 64'(mif.RES_RX2), 64'd0);
    chk("rst_sgn", 64'(mif.SIGNED_RES_RX2), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    directed("xhalf_msb", 64'h00000000_FFFFFFFF, 64'h1, 1'b1, 1'b0, 32'h00000001, 1'b0);
    directed("xhalf_lsb", 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 32'h00000000, 1'b0);
    directed("wrap_msb",  64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b1, 1'b0, 32'h00000000, 1'b0);
    directed("wrap_lsb",  64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 32'h00000000, 1'b0);
    directed("sgn_msb",   64'hFFFFFFFF_FFFFFFF1, 64'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    directed("sgn_lsb",   64'hFFFFFFFF_FFFFFFF1, 64'h0, 1'b0, 1'b1, 32'hFFFFFFF1, 1'b1);

    // streaming with writeback always popping
    wb_en = 1; wb_pct = 100;
    for (int i = 0; i < 4; i++)
      add_src({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    repeat (8) step();
    drain();

    // backpressure until x2wbk fills, then release
    wb_en = 0;
    for (int i = 0; i < 8; i++)
      add_src({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    repeat (10) step();
    chk("bp_inflight", 64'(exp_q.size()), 64'(DEPTH + 1));
    chk("bp_pop_low", 64'(mif.X1X2_POP_SX2), 64'd0);
    chk("bp_busy", 64'(mif.MULT_BUSY_SX2), 64'd1);
    drain();

    // reset with three entries in flight
    wb_en = 0;
    for (int i = 0; i < 6; i++)
      add_src({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
    n = 0;
    while (exp_q.size() < 3 && n < 10) begin
      step();
      n++;
    end
    if (exp_q.size() < 3) timeout("rst_fill");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_empty", 64'(mif.X2WBK_EMPTY_SX2), 64'd1);
    chk("mid_rst_busy", 64'(mif.MULT_BUSY_SX2), 64'd0);
    chk("mid_rst_res", 64'(mif.RES_RX2), 64'd0);
    chk("mid_rst_pop", 64'(mif.X1X2_POP_SX2), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    drain();

    // random traffic with varying writeback pressure
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) wb_pct = $urandom_range(0, 100);
      wb_en = 1;
      if (src_q.size() < 8 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0)
          add_src({$urandom, 32'hFFFFFFFF}, {$urandom, 32'($urandom_range(1, 5))}, 1'($urandom), 1'($urandom));
        else
          add_src({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
